cdf_sequencer: RTL and testbench

CDF_SEQUENCER -- requirements
Module: cdf_sequencer

---
 rtl/histeq_pkg.sv | 37 +++
 rtl/cdf_sequencer_if.sv | 36 +++
 rtl/cdf_sequencer.sv | 125 ++++++++++++
 tb/tb_cdf_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histeq_pkg.sv
// ---------------------------------------------------------------------------
// histeq_pkg -- definitions shared by the histogram-equalisation blocks.
//   NBINS_DEF / SIZE_DEF : default bin count and pixels per frame
//   ADDR_W / DATA_W      : histogram address and count widths
//   LUT_W                : equalisation LUT data width
//   state_t              : cdf_sequencer FSM encoding
//   sat_lut()            : clamps a divider quotient to the LUT range
// ---------------------------------------------------------------------------
package histeq_pkg;

  localparam int NBINS_DEF = 256;
  localparam int SIZE_DEF  = 1600;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int LUT_W     = 8;

  typedef enum logic [3:0] {
    IDLE,
    SCAN_RD,
    SCAN_CHK,
    SUM_RD,
    SUM_ACC,
    SETUP,
    FIRE,
    WAIT,
    WRITE,
    FIN
  } state_t;

  localparam logic [DATA_W-1:0] LUT_MAX = (1 << LUT_W) - 1;

  // Quotients above the LUT range pin to full scale instead of wrapping.
  function automatic logic [LUT_W-1:0] sat_lut(input logic [DATA_W-1:0] g);
    return (g > LUT_MAX) ? {LUT_W{1'b1}} : g[LUT_W-1:0];
  endfunction

endpackage

// File: rtl/cdf_sequencer_if.sv
// ---------------------------------------------------------------------------
// cdf_sequencer_if -- histogram read port, divider port and LUT write port
// of the CDF sequencer, bundled.
//   hist_rd_addr / hist_rd_data : histogram RAM read (data one cycle later)
//   cdf_min / cdf_out / div_en  : divider operands and start pulse
//   g_in / g_ready              : divider quotient and done strobe
//   lut_wr_en/addr/data         : equalisation LUT write
// Modports: master = sequencer side, slave = memory/divider/LUT side.
// ---------------------------------------------------------------------------
interface cdf_sequencer_if;
  import histeq_pkg::*;

  logic [ADDR_W-1:0] hist_rd_addr;
  logic [DATA_W-1:0] hist_rd_data;
  logic [DATA_W-1:0] cdf_min;
  logic [DATA_W-1:0] cdf_out;
  logic              div_en;
  logic [DATA_W-1:0] g_in;
  logic              g_ready;
  logic              lut_wr_en;
  logic [ADDR_W-1:0] lut_wr_addr;
  logic [LUT_W-1:0]  lut_wr_data;

  modport master (
    output hist_rd_addr, cdf_min, cdf_out, div_en,
           lut_wr_en, lut_wr_addr, lut_wr_data,
    input  hist_rd_data, g_in, g_ready
  );

  modport slave (
    input  hist_rd_addr, cdf_min, cdf_out, div_en,
           lut_wr_en, lut_wr_addr, lut_wr_data,
    output hist_rd_data, g_in, g_ready
  );

endinterface

// File: rtl/cdf_sequencer.sv
// ---------------------------------------------------------------------------
// cdf_sequencer -- walks a histogram, finds the first non-zero bin (cdf_min),
// then for every bin accumulates the CDF, hands it to an external divider
// and writes the saturated quotient into the equalisation LUT.
//   clk, reset (async, active low), start (pulse, ignored while busy)
//   busy : high from the cycle after start until done
//   done : one-cycle pulse after the last LUT write
//   bus  : cdf_sequencer_if.master (histogram, divider, LUT ports)
// Optional: define CDF_SUM_CHECK_EN to add sum_err, set in FIN when the
// histogram total differs from SIZE.
// ---------------------------------------------------------------------------
module cdf_sequencer
  import histeq_pkg::*;
#(
  parameter int NBINS = NBINS_DEF,
  parameter int SIZE  = SIZE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef CDF_SUM_CHECK_EN
  output logic sum_err,
`endif
  cdf_sequencer_if.master bus
);

  if (NBINS < 2 || NBINS > (1 << ADDR_W) || SIZE < 1) begin : g_cfg_check
    $error("cdf_sequencer: NBINS must be 2..256 and SIZE positive");
  end

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBINS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] cdf_min_q;
  logic [DATA_W-1:0] cdf_out_q;
  logic [DATA_W-1:0] g_q;
  logic              rd_nz;
  logic              last_bin;

  assign rd_nz    = (bus.hist_rd_data != '0);
  assign last_bin = (i_q == LAST);

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = SCAN_RD;
      SCAN_RD:  state_d = SCAN_CHK;
      // an all-zero histogram still runs the full per-bin pass
      SCAN_CHK: state_d = (rd_nz || last_bin) ? SUM_RD : SCAN_RD;
      SUM_RD:   state_d = SUM_ACC;
      SUM_ACC:  state_d = SETUP;
      // SETUP lets the divider's input registers see a settled cdf_out
      SETUP:    state_d = FIRE;
      FIRE:     state_d = WAIT;
      WAIT:     if (bus.g_ready) state_d = WRITE;
      WRITE:    state_d = last_bin ? FIN : SUM_RD;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // state + datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      sum_q     <= '0;
      cdf_min_q <= '0;
      cdf_out_q <= '0;
      g_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          i_q       <= '0;
          sum_q     <= '0;
          cdf_min_q <= '0;
        end
        SCAN_CHK: begin
          if (rd_nz) begin
            cdf_min_q <= bus.hist_rd_data;
            i_q       <= '0;
          end else if (last_bin) begin
            i_q <= '0;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        // cdf_out only changes here, so it is frozen across SETUP..WRITE
        SUM_ACC: begin
          sum_q     <= sum_q + bus.hist_rd_data;
          cdf_out_q <= sum_q + bus.hist_rd_data;
        end
        WAIT:  if (bus.g_ready) g_q <= bus.g_in;
        WRITE: if (!last_bin) i_q <= i_q + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CDF_SUM_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        sum_err <= 1'b0;
    else if (state_q == IDLE && start) sum_err <= 1'b0;
    else if (state_q == FIN)           sum_err <= (sum_q != DATA_W'(SIZE));
  end
`endif

  // outputs: decoded from state so reset zeroes them without waiting a clock
  assign bus.hist_rd_addr = i_q;
  assign bus.cdf_min      = cdf_min_q;
  assign bus.cdf_out      = cdf_out_q;
  assign bus.div_en       = (state_q == FIRE);
  assign bus.lut_wr_en    = (state_q == WRITE);
  assign bus.lut_wr_addr  = (state_q == WRITE) ? i_q : '0;
  assign bus.lut_wr_data  = (state_q == WRITE) ? sat_lut(g_q) : '0;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FIN);

endmodule

// File: tb/tb_cdf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cdf_sequencer -- directed bench for cdf_sequencer: histogram RAM model,
// divider model with programmable latency, LUT/pulse monitor.
// ---------------------------------------------------------------------------
module tb_cdf_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
`ifdef CDF_SUM_CHECK_EN
  logic sum_err;
`endif

  cdf_sequencer_if bus();

  cdf_sequencer #(.NBINS(256), .SIZE(1600)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef CDF_SUM_CHECK_EN
    .sum_err (sum_err),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // histogram RAM: one-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) bus.hist_rd_data <= mem[bus.hist_rd_addr];

  // environment controls (written by tasks only)
  logic clr = 1'b0;
  int   div_mode = 0;   // 0: histeq formula, 1: quotient = cdf
  int   dly_mode = 0;   // 0: fixed_dly, 1: 0/5/40 by bin
  int   fixed_dly = 0;

  // monitor state (written by env block only)
  logic [7:0]  lut_got [256];
  int          wr_per  [256];
  int          wr_cnt, div_cnt, done_cnt, wr_at_done, stab_err;
  logic        pend = 1'b0;
  int          cnt;
  logic [31:0] cap, cap_min;

  function automatic logic [31:0] div_f(input logic [31:0] c, input logic [31:0] m, input int mode);
    longint q;
    if (mode == 1) return c;
    if (c <= m) return 32'd0;
    q = (longint'(c - m) * 255) / longint'(1600 - m);
    return 32'(q);
  endfunction

  always @(negedge clk) begin
    if (clr) begin
      for (int k = 0; k < 256; k++) begin lut_got[k] = 8'h00; wr_per[k] = 0; end
      wr_cnt = 0; div_cnt = 0; done_cnt = 0; wr_at_done = -1; stab_err = 0;
    end
    if (bus.lut_wr_en) begin
      lut_got[bus.lut_wr_addr] = bus.lut_wr_data;
      wr_per[bus.lut_wr_addr]++;
      wr_cnt++;
      if (bus.cdf_out !== cap) stab_err++;
    end
    if (done) begin done_cnt++; wr_at_done = wr_cnt; end
    if (bus.div_en) div_cnt++;
    bus.g_ready = 1'b0;
    bus.g_in    = 32'hDEAD_BEEF;
    if (!reset) pend = 1'b0;
    else begin
      if (pend) begin
        if (bus.cdf_out !== cap) stab_err++;
        if (cnt == 0) begin
          bus.g_ready = 1'b1;
          bus.g_in    = div_f(cap, cap_min, div_mode);
          pend        = 1'b0;
        end else cnt--;
      end
      if (bus.div_en) begin
        pend    = 1'b1;
        cap     = bus.cdf_out;
        cap_min = bus.cdf_min;
        if (dly_mode == 1)
          cnt = ((div_cnt - 1) % 3 == 0) ? 0 : ((div_cnt - 1) % 3 == 1) ? 5 : 40;
        else
          cnt = fixed_dly;
      end
    end
  end

  task automatic load_histeq();
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[1] = 32'd100;
    mem[2] = 32'd1500;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin @(negedge clk); #1; n++; end
    nchk++;
    if (done_cnt == 0) begin nerr++; $display("FAIL %s_timeout got no done, need done", name); end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_seq(input string name);
    clear_mon();
    pulse_start();
    #1;
    nchk++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
    wait_done(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if ({busy, done, bus.div_en, bus.lut_wr_en} !== 4'b0) begin
      nerr++; $display("FAIL reset_ctl got=%b exp=0000", {busy, done, bus.div_en, bus.lut_wr_en});
    end
    nchk++;
    if ({bus.hist_rd_addr, bus.lut_wr_addr, bus.lut_wr_data} !== 24'd0) begin
      nerr++; $display("FAIL reset_addr got=%h exp=0", {bus.hist_rd_addr, bus.lut_wr_addr, bus.lut_wr_data});
    end
    nchk++;
    if ({bus.cdf_min, bus.cdf_out} !== 64'd0) begin
      nerr++; $display("FAIL reset_cdf got=%h exp=0", {bus.cdf_min, bus.cdf_out});
    end
`ifdef CDF_SUM_CHECK_EN
    nchk++;
    if (sum_err !== 1'b0) begin nerr++; $display("FAIL reset_sum_err got=%b exp=0", sum_err); end
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_histeq();
    int bad = 0;
    load_histeq();
    div_mode = 0; dly_mode = 0; fixed_dly = 2;
    run_seq("histeq");
    for (int k = 2; k < 256; k++) if (lut_got[k] !== 8'd255) bad++;
    nchk++; if (bus.cdf_min !== 32'd100) begin nerr++; $display("FAIL histeq_cdf_min got=%0d exp=100", bus.cdf_min); end
    nchk++; if (bus.cdf_out !== 32'd1600) begin nerr++; $display("FAIL histeq_cdf_out got=%0d exp=1600", bus.cdf_out); end
    nchk++; if (lut_got[0] !== 8'd0 || lut_got[1] !== 8'd0) begin
      nerr++; $display("FAIL histeq_lut01 got=%0d,%0d exp=0,0", lut_got[0], lut_got[1]);
    end
    nchk++; if (bad !== 0) begin nerr++; $display("FAIL histeq_lut_hi got=%0d bad exp=0", bad); end
    nchk++; if (wr_cnt !== 256) begin nerr++; $display("FAIL histeq_writes got=%0d exp=256", wr_cnt); end
    nchk++; if (div_cnt !== 256) begin nerr++; $display("FAIL histeq_div_en got=%0d exp=256", div_cnt); end
    nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL histeq_done got=%0d exp=1", done_cnt); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL histeq_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_all_zero();
    int nz = 0;
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    div_mode = 1; dly_mode = 0; fixed_dly = 0;
    run_seq("zero");
    for (int k = 0; k < 256; k++) if (lut_got[k] !== 8'd0 || wr_per[k] !== 1) nz++;
    nchk++; if (bus.cdf_min !== 32'd0) begin nerr++; $display("FAIL zero_cdf_min got=%0d exp=0", bus.cdf_min); end
    nchk++; if (div_cnt !== 256) begin nerr++; $display("FAIL zero_div_en got=%0d exp=256", div_cnt); end
    nchk++; if (wr_at_done !== 256) begin nerr++; $display("FAIL zero_done_after_last got=%0d exp=256", wr_at_done); end
    nchk++; if (nz !== 0) begin nerr++; $display("FAIL zero_lut got=%0d bad exp=0", nz); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[1] = 32'd3; mem[3] = 32'd250; mem[10] = 32'd5; mem[200] = 32'hFFFF_FFFF;
    div_mode = 1; dly_mode = 0; fixed_dly = 1;
    run_seq("sat");
    nchk++; if (bus.cdf_min !== 32'd3) begin nerr++; $display("FAIL sat_cdf_min got=%0d exp=3", bus.cdf_min); end
    nchk++; if ({lut_got[0], lut_got[1], lut_got[2], lut_got[3], lut_got[9]} !== {8'd0, 8'd3, 8'd3, 8'd253, 8'd253}) begin
      nerr++; $display("FAIL sat_lut_lo got=%h exp=000303fdfd", {lut_got[0], lut_got[1], lut_got[2], lut_got[3], lut_got[9]});
    end
    nchk++; if ({lut_got[10], lut_got[199], lut_got[200], lut_got[255]} !== 32'hFFFF_FFFF) begin
      nerr++; $display("FAIL sat_lut_hi got=%h exp=ffffffff", {lut_got[10], lut_got[199], lut_got[200], lut_got[255]});
    end
    repeat (20) @(negedge clk);
    #1;
    nchk++; if (bus.cdf_out !== 32'd257 || bus.cdf_min !== 32'd3) begin
      nerr++; $display("FAIL sat_wrap_hold got=%0d/%0d exp=257/3", bus.cdf_out, bus.cdf_min);
    end
  endtask

  task automatic test_delays();
    int multi = 0;
    load_histeq();
    div_mode = 0; dly_mode = 1;
    run_seq("dly");
    for (int k = 0; k < 256; k++) if (wr_per[k] !== 1) multi++;
    nchk++; if (multi !== 0) begin nerr++; $display("FAIL dly_one_write got=%0d bad exp=0", multi); end
    nchk++; if (stab_err !== 0) begin nerr++; $display("FAIL dly_cdf_stable got=%0d exp=0", stab_err); end
    nchk++; if (div_cnt !== 256 || wr_cnt !== 256) begin
      nerr++; $display("FAIL dly_counts got=%0d/%0d exp=256/256", div_cnt, wr_cnt);
    end
    nchk++; if (lut_got[1] !== 8'd0 || lut_got[2] !== 8'd255) begin
      nerr++; $display("FAIL dly_lut got=%0d,%0d exp=0,255", lut_got[1], lut_got[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load_histeq();
    div_mode = 0; dly_mode = 0; fixed_dly = 40;
    clear_mon();
    pulse_start();
    while (div_cnt < 18 && n < 5000) begin @(negedge clk); #1; n++; end
    nchk++; if (div_cnt < 18) begin nerr++; $display("FAIL rstmid_reach got=%0d exp=18", div_cnt); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    nchk++; if ({busy, done, bus.div_en, bus.lut_wr_en, bus.hist_rd_addr, bus.lut_wr_addr, bus.lut_wr_data} !== 28'd0) begin
      nerr++; $display("FAIL rstmid_outs got=%h exp=0", {busy, done, bus.div_en, bus.lut_wr_en, bus.hist_rd_addr, bus.lut_wr_addr, bus.lut_wr_data});
    end
    nchk++; if ({bus.cdf_min, bus.cdf_out} !== 64'd0) begin
      nerr++; $display("FAIL rstmid_cdf got=%h exp=0", {bus.cdf_min, bus.cdf_out});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    nchk++; if (wr_cnt !== 17 || div_cnt !== 18) begin
      nerr++; $display("FAIL rstmid_quiet got=wr%0d/div%0d exp=wr17/div18", wr_cnt, div_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    int multi = 0;
    load_histeq();
    div_mode = 0; dly_mode = 0; fixed_dly = 1;
    clear_mon();
    pulse_start();
    while (wr_cnt < 50 && n < 5000) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    nchk++; if (bus.hist_rd_addr !== 8'd50) begin nerr++; $display("FAIL ign_sum_rd_addr got=%0d exp=50", bus.hist_rd_addr); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 256; k++) if (wr_per[k] !== 1) multi++;
    nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
    nchk++; if (multi !== 0 || div_cnt !== 256) begin
      nerr++; $display("FAIL ign_writes got=bad%0d/div%0d exp=bad0/div256", multi, div_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    load_histeq();
    div_mode = 0; dly_mode = 0; fixed_dly = 0;
    clear_mon();
    pulse_start();
    while (wr_cnt < 256 && n < 5000) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL b2b_fin_done got=%b exp=1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    nchk++; if (busy !== 1'b0 || div_cnt !== 256 || done_cnt !== 1) begin
      nerr++; $display("FAIL b2b_fin_start got=busy%b/div%0d/done%0d exp=busy0/div256/done1", busy, div_cnt, done_cnt);
    end
    run_seq("b2b");
    nchk++; if (wr_cnt !== 256 || done_cnt !== 1 || lut_got[2] !== 8'd255) begin
      nerr++; $display("FAIL b2b_second got=wr%0d/done%0d/lut2=%0d exp=256/1/255", wr_cnt, done_cnt, lut_got[2]);
    end
  endtask

`ifdef CDF_SUM_CHECK_EN
  task automatic test_sum_err();
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[5] = 32'd1599;
    div_mode = 0; dly_mode = 0; fixed_dly = 0;
    run_seq("sumerr1599");
    nchk++; if (sum_err !== 1'b1) begin nerr++; $display("FAIL sum_err_1599 got=%b exp=1", sum_err); end
    mem[5] = 32'd1600;
    run_seq("sumerr1600");
    nchk++; if (sum_err !== 1'b0) begin nerr++; $display("FAIL sum_err_1600 got=%b exp=0", sum_err); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    test_reset();
    test_histeq();
    test_all_zero();
    test_saturate();
    test_delays();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
`ifdef CDF_SUM_CHECK_EN
    test_sum_err();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
